// File: rtl/buttons_event_ctrl.sv
// buttons_event_ctrl: polls a button PIO after its interrupt, reads the captured
// edges and current levels, clears the captures, and queues {edges, level}
// events in a small first-word-fall-through FIFO with a sticky overflow flag.
// Optional feature: define BUTTONS_EVENT_TIMESTAMP_EN to add a 16-bit
// free-running cycle counter whose value at the edge read is stored with each
// event and presented on ev_timestamp.
module buttons_event_ctrl #(
    parameter logic [3:0] BUTTON_MASK = 4'hF,
    parameter int         FIFO_DEPTH  = 4
) (
    input  logic        clk,
    input  logic        reset_n,
    output logic [1:0]  m_address,
    output logic        m_chipselect,
    output logic        m_write_n,
    output logic [31:0] m_writedata,
    input  logic [31:0] m_readdata,
    input  logic        pio_irq,
    output logic        ev_valid,
    input  logic        ev_ready,
    output logic [3:0]  ev_edges,
    output logic [3:0]  ev_level,
`ifdef BUTTONS_EVENT_TIMESTAMP_EN
    output logic [15:0] ev_timestamp,
`endif
    output logic        ovf,
    input  logic        ovf_clr
);

    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int CNT_W = $clog2(FIFO_DEPTH + 1);
`ifdef BUTTONS_EVENT_TIMESTAMP_EN
    localparam int ENTRY_W = 24;
`else
    localparam int ENTRY_W = 8;
`endif

    // Writing ones to every capture bit clears them whether the PIO clears on
    // any write or only the bits written as one.
    localparam logic [31:0] CLR_ALL = 32'h0000_000F;

    typedef enum logic [3:0] {
        INIT_MASK,
        INIT_CLR,
        IDLE,
        RD_EC,
        RD_EC_W,
        ACK,
        RD_LVL,
        RD_LVL_W,
        PUSH
    } state_t;

    state_t state_reg, state_next;

    logic [3:0]         edge_reg;
    logic [3:0]         level_reg;
    logic [PTR_W-1:0]   wr_ptr_reg;
    logic [PTR_W-1:0]   rd_ptr_reg;
    logic [CNT_W-1:0]   count_reg;
    logic               ovf_reg;
    logic [ENTRY_W-1:0] push_data;
    logic [ENTRY_W-1:0] head_data;
    logic [ENTRY_W-1:0] slot [FIFO_DEPTH];
    logic               push_req;
    logic               push;
    logic               pop;
    logic               drop;
    logic               full;

    // Only the low nibble of the PIO data carries button information.
    logic unused_readdata;
    assign unused_readdata = ^m_readdata[31:4];

`ifdef BUTTONS_EVENT_TIMESTAMP_EN
    logic [15:0] ts_cnt_reg;
    logic [15:0] ts_reg;

    // Free-running cycle counter, wraps naturally at 16 bits.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            ts_cnt_reg <= 16'h0000;
        end else begin
            ts_cnt_reg <= ts_cnt_reg + 16'h0001;
        end
    end
`endif

    // State register.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_reg <= INIT_MASK;
        end else begin
            state_reg <= state_next;
        end
    end

    // Next-state logic: one PIO access at a time, read data used the cycle after the strobe.
    always_comb begin
        state_next = state_reg;
        case (state_reg)
            INIT_MASK: state_next = INIT_CLR;
            INIT_CLR:  state_next = IDLE;
            IDLE:      if (pio_irq) state_next = RD_EC;
            RD_EC:     state_next = RD_EC_W;
            RD_EC_W:   state_next = (m_readdata[3:0] == 4'b0000) ? IDLE : ACK;
            ACK:       state_next = RD_LVL;
            RD_LVL:    state_next = RD_LVL_W;
            RD_LVL_W:  state_next = PUSH;
            PUSH:      state_next = IDLE;
            default:   state_next = INIT_MASK;
        endcase
    end

    // Master-port outputs per state; held idle while reset is asserted.
    always_comb begin
        m_chipselect = 1'b0;
        m_write_n    = 1'b1;
        m_address    = 2'd0;
        m_writedata  = 32'h0;
        case (state_reg)
            INIT_MASK: begin
                m_chipselect = 1'b1;
                m_write_n    = 1'b0;
                m_address    = 2'd2;
                m_writedata  = {28'b0, BUTTON_MASK};
            end
            INIT_CLR, ACK: begin
                m_chipselect = 1'b1;
                m_write_n    = 1'b0;
                m_address    = 2'd3;
                m_writedata  = CLR_ALL;
            end
            RD_EC: begin
                m_chipselect = 1'b1;
                m_address    = 2'd3;
            end
            RD_EC_W: begin
                m_address    = 2'd3;
            end
            RD_LVL: begin
                m_chipselect = 1'b1;
                m_address    = 2'd0;
            end
            default: ;
        endcase
        if (!reset_n) begin
            m_chipselect = 1'b0;
            m_write_n    = 1'b1;
            m_address    = 2'd0;
            m_writedata  = 32'h0;
        end
    end

    // Latch edge and level read data in the wait state of each read.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            edge_reg  <= 4'b0000;
            level_reg <= 4'b0000;
`ifdef BUTTONS_EVENT_TIMESTAMP_EN
            ts_reg    <= 16'h0000;
`endif
        end else begin
            if (state_reg == RD_EC_W) begin
                edge_reg <= m_readdata[3:0];
`ifdef BUTTONS_EVENT_TIMESTAMP_EN
                ts_reg   <= ts_cnt_reg;
`endif
            end
            if (state_reg == RD_LVL_W) begin
                level_reg <= m_readdata[3:0];
            end
        end
    end

`ifdef BUTTONS_EVENT_TIMESTAMP_EN
    assign push_data = {ts_reg, edge_reg, level_reg};
`else
    assign push_data = {edge_reg, level_reg};
`endif

    // A full FIFO still accepts the event when the head leaves in the same cycle.
    assign push_req = (state_reg == PUSH);
    assign full     = (count_reg == CNT_W'(FIFO_DEPTH));
    assign pop      = ev_valid && ev_ready;
    assign push     = push_req && (!full || pop);
    assign drop     = push_req && full && !pop;

    genvar gi;
    generate
        for (gi = 0; gi < FIFO_DEPTH; gi++) begin : g_slot
            logic [ENTRY_W-1:0] data_reg;

            // Storage for one FIFO entry, written when the write pointer selects it.
            always_ff @(posedge clk) begin
                if (push && (wr_ptr_reg == PTR_W'(gi))) begin
                    data_reg <= push_data;
                end
            end

            assign slot[gi] = data_reg;
        end
    endgenerate

    // FIFO pointers, occupancy and sticky overflow (set beats clear).
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
            ovf_reg    <= 1'b0;
        end else begin
            if (push) begin
                wr_ptr_reg <= wr_ptr_reg + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr_reg <= rd_ptr_reg + PTR_W'(1);
            end
            case ({push, pop})
                2'b10:   count_reg <= count_reg + CNT_W'(1);
                2'b01:   count_reg <= count_reg - CNT_W'(1);
                default: count_reg <= count_reg;
            endcase
            if (drop) begin
                ovf_reg <= 1'b1;
            end else if (ovf_clr) begin
                ovf_reg <= 1'b0;
            end
        end
    end

    assign head_data = slot[rd_ptr_reg];
    assign ev_valid  = reset_n && (count_reg != '0);
    assign ev_edges  = ev_valid ? head_data[7:4] : 4'b0000;
    assign ev_level  = ev_valid ? head_data[3:0] : 4'b0000;
    assign ovf       = reset_n && ovf_reg;
`ifdef BUTTONS_EVENT_TIMESTAMP_EN
    assign ev_timestamp = ev_valid ? head_data[23:8] : 16'h0000;
`endif

endmodule

// File: tb/tb_buttons_event_ctrl.sv
// Directed bench for buttons_event_ctrl with a small behavioural button PIO:
// registered read data (latency 1), irq_mask, edge_capture cleared by writes
// to address 3 (a clear write beats a capture in the same cycle).
module tb_buttons_event_ctrl;

    logic        clk = 1'b0;
    logic        reset_n;
    logic [1:0]  m_address;
    logic        m_chipselect;
    logic        m_write_n;
    logic [31:0] m_writedata;
    logic [31:0] m_readdata = 32'h0;
    logic        pio_irq;
    logic        ev_valid;
    logic        ev_ready;
    logic [3:0]  ev_edges;
    logic [3:0]  ev_level;
    logic        ovf;
    logic        ovf_clr;
`ifdef BUTTONS_EVENT_TIMESTAMP_EN
    logic [15:0] ev_timestamp;
    logic [15:0] tb_cyc = 16'h0;
    logic [15:0] ts_exp;
`endif

    logic [3:0] pio_ec    = 4'h0;
    logic [3:0] pio_mask  = 4'h0;
    logic [3:0] lvl       = 4'h0;
    logic [3:0] inject    = 4'h0;
    logic       force_irq = 1'b0;
    int         ack_cnt   = 0;
    int         ack0;

    int checks   = 0;
    int failures = 0;

    buttons_event_ctrl #(
        .BUTTON_MASK(4'hF),
        .FIFO_DEPTH (4)
    ) dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .m_address   (m_address),
        .m_chipselect(m_chipselect),
        .m_write_n   (m_write_n),
        .m_writedata (m_writedata),
        .m_readdata  (m_readdata),
        .pio_irq     (pio_irq),
        .ev_valid    (ev_valid),
        .ev_ready    (ev_ready),
        .ev_edges    (ev_edges),
        .ev_level    (ev_level),
`ifdef BUTTONS_EVENT_TIMESTAMP_EN
        .ev_timestamp(ev_timestamp),
`endif
        .ovf         (ovf),
        .ovf_clr     (ovf_clr)
    );

    always #5 clk = ~clk;

    // Button PIO model.
    always @(posedge clk) begin
        if (m_chipselect && m_write_n) begin
            case (m_address)
                2'd0:    m_readdata <= {28'b0, lvl};
                2'd2:    m_readdata <= {28'b0, pio_mask};
                2'd3:    m_readdata <= {28'b0, pio_ec};
                default: m_readdata <= 32'h0;
            endcase
        end
        if (m_chipselect && !m_write_n && m_address == 2'd2) begin
            pio_mask <= m_writedata[3:0];
        end
        if (m_chipselect && !m_write_n && m_address == 2'd3) begin
            pio_ec  <= 4'h0;
            ack_cnt <= ack_cnt + 1;
        end else begin
            pio_ec <= pio_ec | inject;
        end
    end

    assign pio_irq = (|(pio_ec & pio_mask)) | force_irq;

`ifdef BUTTONS_EVENT_TIMESTAMP_EN
    always @(posedge clk) begin
        if (!reset_n) tb_cyc <= 16'h0;
        else          tb_cyc <= tb_cyc + 16'h1;
    end
`endif

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got=0x%0h expected=0x%0h", tag, got, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Capture edges in the PIO on the next rising edge; returns one cycle later.
    task automatic press(input logic [3:0] e);
        inject = e;
        @(negedge clk);
        inject = 4'h0;
    endtask

    // Full event with the consumer idle; ends back in IDLE.
    task automatic do_event(input logic [3:0] e, input logic [3:0] l);
        lvl = l;
        press(e);
        step(9);
    endtask

    task automatic pop_check(input string tag, input logic [3:0] e, input logic [3:0] l);
        check_eq({tag, "_valid"}, ev_valid, 1'b1);
        check_eq({tag, "_edges"}, ev_edges, e);
        check_eq({tag, "_level"}, ev_level, l);
        $display("pop %s edges=%b level=%b", tag, ev_edges, ev_level);
        ev_ready = 1'b1;
        step(1);
        ev_ready = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL timeout: simulation did not complete");
        $fatal(1, "timeout");
    end

    initial begin
        reset_n = 1'b0;
        ev_ready = 1'b0;
        ovf_clr = 1'b0;
        step(3);

        // Reset state.
        check_eq("rst_valid", ev_valid, 1'b0);
        check_eq("rst_edges", ev_edges, 4'h0);
        check_eq("rst_level", ev_level, 4'h0);
        check_eq("rst_ovf", ovf, 1'b0);
        check_eq("rst_cs", m_chipselect, 1'b0);

        // Init sequence after release.
        reset_n = 1'b1;
        #1;
        check_eq("init_mask_cs", m_chipselect, 1'b1);
        check_eq("init_mask_wn", m_write_n, 1'b0);
        check_eq("init_mask_addr", m_address, 2'd2);
        check_eq("init_mask_wd", m_writedata, 32'h0000000F);
        step(1);
        check_eq("init_clr_cs", m_chipselect, 1'b1);
        check_eq("init_clr_wn", m_write_n, 1'b0);
        check_eq("init_clr_addr", m_address, 2'd3);
        step(1);
        check_eq("idle_cs", m_chipselect, 1'b0);
        check_eq("idle_wn", m_write_n, 1'b1);
        check_eq("idle_addr", m_address, 2'd0);
        check_eq("pio_mask", pio_mask, 4'hF);
        $display("init done");

        // Single event, latency 7 from pio_irq.
        ev_ready = 1'b1;
        lvl = 4'b0010;
        press(4'b0010);
        check_eq("lat_irq", pio_irq, 1'b1);
        step(6);
        check_eq("lat_pre_valid", ev_valid, 1'b0);
        step(1);
        check_eq("ev1_valid", ev_valid, 1'b1);
        check_eq("ev1_edges", ev_edges, 4'b0010);
        check_eq("ev1_level", ev_level, 4'b0010);
        $display("event ev1 edges=%b level=%b", ev_edges, ev_level);
        step(1);
        check_eq("ev1_popped", ev_valid, 1'b0);
        ev_ready = 1'b0;
        step(2);

        // Spurious interrupt: read returns 0, no ACK write, no event.
        ack0 = ack_cnt;
        force_irq = 1'b1;
        step(1);
        force_irq = 1'b0;
        check_eq("spur_rd_cs", m_chipselect, 1'b1);
        check_eq("spur_rd_addr", m_address, 2'd3);
        check_eq("spur_rd_wn", m_write_n, 1'b1);
        step(2);
        check_eq("spur_idle_cs", m_chipselect, 1'b0);
        step(4);
        check_eq("spur_no_ack", ack_cnt, ack0);
        check_eq("spur_no_event", ev_valid, 1'b0);
        $display("spurious irq handled");

        // Fill FIFO, drop fifth with ovf_clr held in the drop cycle.
        do_event(4'b0001, 4'b0001);
        do_event(4'b0010, 4'b0011);
        do_event(4'b0100, 4'b0111);
        do_event(4'b1000, 4'b1000);
        check_eq("full_no_ovf", ovf, 1'b0);
        check_eq("full_head_edges", ev_edges, 4'b0001);
        check_eq("full_head_level", ev_level, 4'b0001);
        lvl = 4'b1100;
        press(4'b0011);
        step(6);
        ovf_clr = 1'b1;
        step(1);
        ovf_clr = 1'b0;
        check_eq("ovf_set_wins", ovf, 1'b1);
        step(1);
        check_eq("ovf_sticky", ovf, 1'b1);
        $display("event ev5 dropped ovf=%b", ovf);
        ovf_clr = 1'b1;
        step(1);
        ovf_clr = 1'b0;
        check_eq("ovf_cleared", ovf, 1'b0);
        check_eq("drop_head_edges", ev_edges, 4'b0001);

        // Full FIFO with a pop in the PUSH cycle: accepted, no overflow.
        lvl = 4'b1001;
        press(4'b0101);
        step(6);
        ev_ready = 1'b1;
        step(1);
        ev_ready = 1'b0;
        check_eq("fullpop_ovf", ovf, 1'b0);
        $display("event ev6 pushed while full with pop");
        pop_check("q0", 4'b0010, 4'b0011);
        pop_check("q1", 4'b0100, 4'b0111);
        pop_check("q2", 4'b1000, 4'b1000);
        pop_check("q3", 4'b0101, 4'b1001);
        check_eq("empty_valid", ev_valid, 1'b0);
        check_eq("empty_edges", ev_edges, 4'h0);
        check_eq("empty_level", ev_level, 4'h0);

        // Reset during RD_LVL_W with one event queued.
        do_event(4'b0100, 4'b0110);
        check_eq("pre_rst_valid", ev_valid, 1'b1);
        lvl = 4'b1010;
        press(4'b0001);
        step(5);
        check_eq("rdlvlw_cs", m_chipselect, 1'b0);
        check_eq("rdlvlw_addr", m_address, 2'd0);
        reset_n = 1'b0;
        step(1);
        check_eq("midrst_valid", ev_valid, 1'b0);
        check_eq("midrst_cs", m_chipselect, 1'b0);
        reset_n = 1'b1;
        #1;
        check_eq("restart_cs", m_chipselect, 1'b1);
        check_eq("restart_addr", m_address, 2'd2);
        check_eq("restart_wn", m_write_n, 1'b0);
        step(1);
        check_eq("restart_empty", ev_valid, 1'b0);
        step(1);
        $display("mid-sequence reset recovered");

        // Event after restart.
        lvl = 4'b0011;
        press(4'b0010);
`ifdef BUTTONS_EVENT_TIMESTAMP_EN
        ts_exp = tb_cyc + 16'd2;
`endif
        step(7);
        check_eq("post_valid", ev_valid, 1'b1);
        check_eq("post_edges", ev_edges, 4'b0010);
        check_eq("post_level", ev_level, 4'b0011);
`ifdef BUTTONS_EVENT_TIMESTAMP_EN
        check_eq("post_ts", ev_timestamp, ts_exp);
`endif
        $display("event post edges=%b level=%b", ev_edges, ev_level);
        ev_ready = 1'b1;
        step(1);
        ev_ready = 1'b0;
        check_eq("post_empty", ev_valid, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
